multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle CPU control unit: a Moore-style state machine that sequences each instruction over several clock cycles, sharing one ALU and one memory port between fetch, address calculation and data access. It sits between the instruction register and the datapath multiplexers and enables. It adds four things the single-cycle unit lacks:
- a parametrised opcode width;
- a memory ready/wait handshake;
- branch-not-equal and halt support;
- an illegal-opcode flag and a retired-instruction counter.

## Interface
Parameters:
- OP_W, 4, opcode width; opcodes occupy Op[3:0]; when OP_W > 4, any nonzero bit above bit 3 makes the opcode illegal.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Op  in  OP_W  opcode from instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed access this cycle.
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/selects.
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- halted  out  1  high in HALT state.
- illegal_op  out  1  one-cycle pulse on illegal opcode.
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W.

## Operation
Opcodes:
- 0000–0101: R-type; ALU op equals Op[2:0].
- 0110: ADDI.
- 0111: LOAD.
- 1000: STORE.
- 1001: BEQ.
- 1010: BNE.
- 1111: HALT.
- All others: illegal.

States and transitions:
- FETCH: AdrSrc=0, ALUSrcA=00 (PC), ALUSrcB=10 (constant 4), add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Moves to DECODE when mem_ready=1, else stays.
- DECODE: ALUSrcA=01 (old PC), ALUSrcB=01 (imm), add; the branch target is latched by the datapath.
  - ImmSrc is driven by Op: 00 for ADDI/LOAD, 01 for STORE, 10 for BEQ/BNE.
  - Next state: R-type→EXECR, ADDI→EXECI, LOAD/STORE→MEMADR, BEQ/BNE→BRANCH, HALT→HALT, illegal→FETCH with illegal_op=1.
- EXECR: ALUSrcA=10 (rs1), ALUSrcB=00 (rs2), ALUControl=Op[2:0]. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, add. Next state ALUWB.
- ALUWB: ResultSrc=00 (ALUOut), RegWrite=1. Retires. Next state FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. LOAD→MEMRD, STORE→MEMWR.
- MEMRD: AdrSrc=1. Waits for mem_ready, then moves to MEMWB.
- MEMWB: ResultSrc=01 (data), RegWrite=1. Retires. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=1 held until mem_ready. Retires on the mem_ready cycle, then moves to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero for BEQ, ~Zero for BNE; this is combinational on Zero.
  - Retires. Next state FETCH.
- HALT: all enables 0, halted=1. Remains in HALT until reset.

Output rules:
- Every enable not listed for a state is 0; every select not listed is 00.
- Illegal opcodes do not increment retired.

## Timing
- Reset (rst_n low): state=FETCH, retired=0. All outputs are forced to 0, including PCWrite and IRWrite, regardless of mem_ready.
- Outputs are combinational from the state register (plus Op in DECODE, Zero in BRANCH, mem_ready in FETCH/MEMWR).
- Latency with mem_ready tied high:
  - R-type/ADDI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - Illegal: 2 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds 1 cycle.
- retired updates on the clock edge that leaves a retiring state; it reads all-ones→0 on wrap.
- Reset asserted mid-instruction aborts immediately; no pending write completes after reset is released.
- Op must be stable from DECODE through the instruction's final state; the IR is not rewritten outside FETCH.

## Test plan
- Reset, then hold mem_ready=1, Op=0000 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 in cycle 4 only; retired=1 after 4 cycles.
- LOAD with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles, AdrSrc=1 throughout, total 8 cycles; RegWrite with ResultSrc=01 exactly once.
- STORE with mem_ready=0 → MemWrite stays 1 until mem_ready rises, then FETCH next cycle; retired increments once.
- BEQ with Zero=1 → PCWrite=1 in BRANCH. BNE with Zero=1 → PCWrite=0. Each takes 3 cycles.
- Op=1011 → illegal_op pulses 1 cycle after DECODE; back in FETCH; retired unchanged. Op=1111 → halted=1 and all enables 0 for 20 cycles.
- CNT_W=2: retire 5 instructions → retired reads 1. Assert rst_n low mid-MEMWR → MemWrite drops to 0 immediately; state FETCH after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch, decode, execute, memory and
// write-back over one shared ALU and memory port, with a memory handshake and a retire counter.
module multicycle_control_unit #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  Op,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             halted,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR,
      S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_HALT
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] retired_r;
   logic             illegal_r;
   logic             op_hi_s;
   logic [3:0]       op_lo_s;
   logic is_rtype_s, is_addi_s, is_load_s, is_store_s, is_beq_s, is_bne_s, is_halt_s, is_illegal_s;
   logic retire_s;
   logic pcwrite_s, adrsrc_s, irwrite_s, memwrite_s, regwrite_s, halted_s;
   logic [1:0] resultsrc_s, alusrca_s, alusrcb_s, immsrc_s;
   logic [2:0] alucontrol_s;

   assign op_lo_s = Op[3:0];

   // Any set bit above the 4-bit opcode field makes the instruction illegal.
   generate
      if (OP_W > 4) begin : g_op_hi
         assign op_hi_s = |Op[OP_W-1:4];
      end else begin : g_no_op_hi
         assign op_hi_s = 1'b0;
      end
   endgenerate

   // Opcode classification.
   always_comb begin
      is_rtype_s   = 1'b0;
      is_addi_s    = 1'b0;
      is_load_s    = 1'b0;
      is_store_s   = 1'b0;
      is_beq_s     = 1'b0;
      is_bne_s     = 1'b0;
      is_halt_s    = 1'b0;
      is_illegal_s = 1'b0;
      if (op_hi_s) begin
         is_illegal_s = 1'b1;
      end else begin
         case (op_lo_s)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0101: is_rtype_s = 1'b1;
            4'b0110:                   is_addi_s  = 1'b1;
            4'b0111:                   is_load_s  = 1'b1;
            4'b1000:                   is_store_s = 1'b1;
            4'b1001:                   is_beq_s   = 1'b1;
            4'b1010:                   is_bne_s   = 1'b1;
            4'b1111:                   is_halt_s  = 1'b1;
            default:                   is_illegal_s = 1'b1;
         endcase
      end
   end

   // Next-state and retire decision.
   always_comb begin
      state_nxt_s = state_r;
      retire_s    = 1'b0;
      case (state_r)
         S_FETCH:  state_nxt_s = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_rtype_s)                    state_nxt_s = S_EXECR;
            else if (is_addi_s)                state_nxt_s = S_EXECI;
            else if (is_load_s || is_store_s)  state_nxt_s = S_MEMADR;
            else if (is_beq_s || is_bne_s)     state_nxt_s = S_BRANCH;
            else if (is_halt_s)                state_nxt_s = S_HALT;
            else                               state_nxt_s = S_FETCH;
         end
         S_EXECR, S_EXECI: state_nxt_s = S_ALUWB;
         S_ALUWB, S_MEMWB, S_BRANCH: begin
            state_nxt_s = S_FETCH;
            retire_s    = 1'b1;
         end
         S_MEMADR: begin
            if (is_load_s)       state_nxt_s = S_MEMRD;
            else if (is_store_s) state_nxt_s = S_MEMWR;
            else                 state_nxt_s = S_FETCH;
         end
         S_MEMRD:  state_nxt_s = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            state_nxt_s = mem_ready ? S_FETCH : S_MEMWR;
            retire_s    = mem_ready;
         end
         S_HALT:   state_nxt_s = S_HALT;
         default:  state_nxt_s = S_FETCH;
      endcase
   end

   // State register, retire counter and illegal-opcode pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_FETCH;
         retired_r <= {CNT_W{1'b0}};
         illegal_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         if (retire_s) retired_r <= retired_r + CNT_W'(1);
         else          retired_r <= retired_r;
         illegal_r <= (state_r == S_DECODE) && is_illegal_s;
      end
   end

   // Datapath controls decoded from the current state.
   always_comb begin
      pcwrite_s    = 1'b0;
      adrsrc_s     = 1'b0;
      irwrite_s    = 1'b0;
      memwrite_s   = 1'b0;
      regwrite_s   = 1'b0;
      halted_s     = 1'b0;
      resultsrc_s  = 2'b00;
      alusrca_s    = 2'b00;
      alusrcb_s    = 2'b00;
      immsrc_s     = 2'b00;
      alucontrol_s = 3'b000;
      case (state_r)
         S_FETCH: begin
            alusrcb_s   = 2'b10;
            resultsrc_s = 2'b10;
            irwrite_s   = mem_ready;
            pcwrite_s   = mem_ready;
         end
         S_DECODE: begin
            alusrca_s = 2'b01;
            alusrcb_s = 2'b01;
            if (is_store_s)                 immsrc_s = 2'b01;
            else if (is_beq_s || is_bne_s)  immsrc_s = 2'b10;
            else                            immsrc_s = 2'b00;
         end
         S_EXECR: begin
            alusrca_s    = 2'b10;
            alucontrol_s = Op[2:0];
         end
         S_EXECI, S_MEMADR: begin
            alusrca_s = 2'b10;
            alusrcb_s = 2'b01;
         end
         S_ALUWB:  regwrite_s = 1'b1;
         S_MEMRD:  adrsrc_s   = 1'b1;
         S_MEMWB: begin
            resultsrc_s = 2'b01;
            regwrite_s  = 1'b1;
         end
         S_MEMWR: begin
            adrsrc_s   = 1'b1;
            memwrite_s = 1'b1;
         end
         S_BRANCH: begin
            alusrca_s    = 2'b10;
            alucontrol_s = 3'b001;
            pcwrite_s    = is_bne_s ? ~Zero : Zero;
         end
         S_HALT:   halted_s = 1'b1;
         default:  halted_s = 1'b0;
      endcase
   end

   // Reset holds every output low even though FETCH would follow mem_ready.
   assign PCWrite    = rst_n & pcwrite_s;
   assign AdrSrc     = rst_n & adrsrc_s;
   assign IRWrite    = rst_n & irwrite_s;
   assign MemWrite   = rst_n & memwrite_s;
   assign RegWrite   = rst_n & regwrite_s;
   assign halted     = rst_n & halted_s;
   assign ResultSrc  = rst_n ? resultsrc_s  : 2'b00;
   assign ALUSrcA    = rst_n ? alusrca_s    : 2'b00;
   assign ALUSrcB    = rst_n ? alusrcb_s    : 2'b00;
   assign ImmSrc     = rst_n ? immsrc_s     : 2'b00;
   assign ALUControl = rst_n ? alucontrol_s : 3'b000;
   assign illegal_op = illegal_r;
   assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control-word checks for every
// instruction class, memory stalls, halt, illegal opcodes, counter wrap and mid-write reset.
module tb_multicycle_control_unit;

   logic        clk, rst_n;
   logic [3:0]  op;
   logic        zero, mem_ready;
   logic        pcw, adr, irw, mw, rw, hlt, ill;
   logic [1:0]  rs, sa, sb, imm;
   logic [2:0]  alu;
   logic [15:0] ret;
   logic [16:0] ctrl;

   logic [4:0]  op2;
   logic        zero2, mem_ready2;
   logic        pcw2, adr2, irw2, mw2, rw2, hlt2, ill2;
   logic [1:0]  rs2, sa2, sb2, imm2;
   logic [2:0]  alu2;
   logic [1:0]  ret2;
   logic [16:0] ctrl2;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .Op(op), .Zero(zero), .mem_ready(mem_ready),
      .PCWrite(pcw), .AdrSrc(adr), .IRWrite(irw), .MemWrite(mw), .RegWrite(rw),
      .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb), .ImmSrc(imm), .ALUControl(alu),
      .halted(hlt), .illegal_op(ill), .retired(ret)
   );

   multicycle_control_unit #(.OP_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .Op(op2), .Zero(zero2), .mem_ready(mem_ready2),
      .PCWrite(pcw2), .AdrSrc(adr2), .IRWrite(irw2), .MemWrite(mw2), .RegWrite(rw2),
      .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2), .ALUControl(alu2),
      .halted(hlt2), .illegal_op(ill2), .retired(ret2)
   );

   assign ctrl  = {pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, hlt};
   assign ctrl2 = {pcw2, adr2, irw2, mw2, rw2, rs2, sa2, sb2, imm2, alu2, hlt2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   function automatic logic [16:0] sig(input logic p, input logic a, input logic i, input logic m,
                                       input logic r, input logic [1:0] s_rs, input logic [1:0] s_a,
                                       input logic [1:0] s_b, input logic [1:0] s_imm,
                                       input logic [2:0] s_alu, input logic h);
      return {p, a, i, m, r, s_rs, s_a, s_b, s_imm, s_alu, h};
   endfunction

   function automatic logic [16:0] f_fetch(input logic mr);
      return sig(mr, 1'b0, mr, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_decode(input logic [1:0] i);
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, i, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_execr(input logic [2:0] a);
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, a, 1'b0);
   endfunction
   function automatic logic [16:0] f_execi();
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_aluwb();
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_memrd();
      return sig(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_memwb();
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_memwr();
      return sig(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
   endfunction
   function automatic logic [16:0] f_branch(input logic p);
      return sig(p, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
   endfunction
   function automatic logic [16:0] f_halt();
      return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = 4'b0000;
      zero2 = 1'b0; mem_ready2 = 1'b0; op2 = 5'b00000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b1; op = 4'b0000;
      #1;
      n_tests++;
      if (ctrl !== 17'd0 || ret !== 16'd0 || ill !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ctrl=%b ret=%0d ill=%b, expected all zero", ctrl, ret, ill);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL reset_release_fetch: got %b, expected %b", ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_rtype(input logic [3:0] opc);
      logic [16:0] exp [0:3];
      exp = '{f_fetch(1'b1), f_decode(2'b00), f_execr(opc[2:0]), f_aluwb()};
      do_reset();
      op = opc; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (ctrl !== exp[i]) begin
            n_fail++;
            $display("FAIL rtype_%b_step%0d: got %b, expected %b", opc, i, ctrl, exp[i]);
         end
         @(negedge clk);
      end
      #1;
      n_tests++;
      if (ret !== 16'd1 || ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL rtype_%b_retire: got ret=%0d ctrl=%b, expected ret=1 ctrl=%b", opc, ret, ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_load();
      logic [16:0] exp [0:7];
      logic        mr  [0:7];
      int          wb_count;
      exp = '{f_fetch(1'b1), f_decode(2'b00), f_execi(), f_memrd(), f_memrd(), f_memrd(), f_memrd(), f_memwb()};
      mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      wb_count = 0;
      do_reset();
      op = 4'b0111;
      for (int i = 0; i < 8; i++) begin
         mem_ready = mr[i];
         #1;
         if (rw === 1'b1 && rs === 2'b01) wb_count++;
         n_tests++;
         if (ctrl !== exp[i]) begin
            n_fail++;
            $display("FAIL load_step%0d: got %b, expected %b", i, ctrl, exp[i]);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      n_tests++;
      if (wb_count != 1 || ret !== 16'd1 || ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL load_done: got wb=%0d ret=%0d ctrl=%b, expected wb=1 ret=1 ctrl=%b", wb_count, ret, ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_store();
      logic [16:0] exp [0:5];
      logic        mr  [0:5];
      exp = '{f_fetch(1'b1), f_decode(2'b01), f_execi(), f_memwr(), f_memwr(), f_memwr()};
      mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      op = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         mem_ready = mr[i];
         #1;
         n_tests++;
         if (ctrl !== exp[i] || ret !== 16'd0) begin
            n_fail++;
            $display("FAIL store_step%0d: got %b ret=%0d, expected %b ret=0", i, ctrl, ret, exp[i]);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      n_tests++;
      if (ret !== 16'd1 || ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL store_done: got ret=%0d ctrl=%b, expected ret=1 ctrl=%b", ret, ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_branch(input logic [3:0] opc, input logic z, input logic taken);
      do_reset();
      op = opc; mem_ready = 1'b1; zero = z;
      #1;
      n_tests++;
      if (ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL branch_%b_fetch: got %b, expected %b", opc, ctrl, f_fetch(1'b1));
      end
      @(negedge clk); #1;
      n_tests++;
      if (ctrl !== f_decode(2'b10)) begin
         n_fail++;
         $display("FAIL branch_%b_decode: got %b, expected %b", opc, ctrl, f_decode(2'b10));
      end
      @(negedge clk); #1;
      n_tests++;
      if (ctrl !== f_branch(taken)) begin
         n_fail++;
         $display("FAIL branch_%b_z%b: got %b, expected %b", opc, z, ctrl, f_branch(taken));
      end
      zero = ~z;
      #1;
      n_tests++;
      if (pcw !== ~taken) begin
         n_fail++;
         $display("FAIL branch_%b_zflip: got PCWrite=%b, expected %b", opc, pcw, ~taken);
      end
      @(negedge clk); #1;
      n_tests++;
      if (ret !== 16'd1 || ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL branch_%b_done: got ret=%0d ctrl=%b, expected ret=1 ctrl=%b", opc, ret, ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_illegal();
      do_reset();
      op = 4'b1011; mem_ready = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (ctrl !== f_decode(2'b00) || ill !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_decode: got %b ill=%b, expected %b ill=0", ctrl, ill, f_decode(2'b00));
      end
      @(negedge clk); #1;
      n_tests++;
      if (ill !== 1'b1 || ctrl !== f_fetch(1'b1) || ret !== 16'd0) begin
         n_fail++;
         $display("FAIL illegal_pulse: got ill=%b ctrl=%b ret=%0d, expected ill=1 ctrl=%b ret=0", ill, ctrl, ret, f_fetch(1'b1));
      end
      @(negedge clk); #1;
      n_tests++;
      if (ill !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_width: got ill=%b, expected 0", ill);
      end
   endtask

   task automatic test_halt();
      do_reset();
      op = 4'b1111; mem_ready = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (ctrl !== f_decode(2'b00)) begin
         n_fail++;
         $display("FAIL halt_decode: got %b, expected %b", ctrl, f_decode(2'b00));
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = i[0];
         #1;
         n_tests++;
         if (ctrl !== f_halt() || ret !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_cycle%0d: got %b ret=%0d, expected %b ret=0", i, ctrl, ret, f_halt());
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mem_ready = 1'b1; zero = 1'b0; op = 4'b0110;
      repeat (4) @(negedge clk);
      op = 4'b1001;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (ctrl !== f_branch(1'b0) || ret !== 16'd1) begin
         n_fail++;
         $display("FAIL b2b_branch: got %b ret=%0d, expected %b ret=1", ctrl, ret, f_branch(1'b0));
      end
      @(negedge clk);
      op = 4'b0010;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (ctrl !== f_execr(3'b010)) begin
         n_fail++;
         $display("FAIL b2b_execr: got %b, expected %b", ctrl, f_execr(3'b010));
      end
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (ret !== 16'd3 || ctrl !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL b2b_done: got ret=%0d ctrl=%b, expected ret=3 ctrl=%b", ret, ctrl, f_fetch(1'b1));
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_ret [0:4];
      exp_ret = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      op2 = 5'b00110; mem_ready2 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         repeat (4) @(negedge clk);
         #1;
         n_tests++;
         if (ret2 !== exp_ret[k]) begin
            n_fail++;
            $display("FAIL wrap_count%0d: got %0d, expected %0d", k, ret2, exp_ret[k]);
         end
      end
      op2 = 5'b10000;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (ill2 !== 1'b1 || ret2 !== 2'd1 || ctrl2 !== f_fetch(1'b1)) begin
         n_fail++;
         $display("FAIL wide_op_illegal: got ill=%b ret=%0d ctrl=%b, expected ill=1 ret=1 ctrl=%b", ill2, ret2, ctrl2, f_fetch(1'b1));
      end
   endtask

   task automatic test_reset_midwrite();
      do_reset();
      op = 4'b1000; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (mw !== 1'b1) begin
         n_fail++;
         $display("FAIL midwrite_memwrite: got %b, expected 1", mw);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (mw !== 1'b0 || ctrl !== 17'd0) begin
         n_fail++;
         $display("FAIL midwrite_abort: got MemWrite=%b ctrl=%b, expected 0", mw, ctrl);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      n_tests++;
      if (ctrl !== f_fetch(1'b1) || ret !== 16'd0) begin
         n_fail++;
         $display("FAIL midwrite_release: got %b ret=%0d, expected %b ret=0", ctrl, ret, f_fetch(1'b1));
      end
   endtask

   initial begin
      rst_n = 1'b0; op = 4'b0000; zero = 1'b0; mem_ready = 1'b0;
      op2 = 5'b00000; zero2 = 1'b0; mem_ready2 = 1'b0;
      test_reset();
      test_rtype(4'b0000);
      test_rtype(4'b0101);
      test_load();
      test_store();
      test_branch(4'b1001, 1'b1, 1'b1);
      test_branch(4'b1010, 1'b1, 1'b0);
      test_illegal();
      test_halt();
      test_back_to_back();
      test_wrap();
      test_reset_midwrite();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
